// File: rtl/cp2_port_arbiter.sv
// Two-requester round-robin arbiter for the CP2 coprocessor handshake port.
// One operation (AS/TS/FS) in flight at a time; a watchdog turns a hung CP2 into an exception.
module cp2_port_arbiter #(
  parameter int unsigned      DATA_W       = 32,
  parameter int unsigned      EXC_W        = 4,
  parameter int unsigned      TIMEOUT      = 255,
  parameter logic [EXC_W-1:0] TIMEOUT_CODE = 'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_ir,
  input  logic [2*DATA_W-1:0]   req_tdata,
  output logic [1:0]            req_done,
  output logic [1:0]            req_busy,
  output logic [DATA_W-1:0]     rsp_fdata,
  output logic                  rsp_exc,
  output logic [EXC_W-1:0]      rsp_exccode,
  output logic [1:0]            grant,
  output logic                  cp2_as,
  output logic                  cp2_ts,
  output logic                  cp2_fs,
  output logic [DATA_W-1:0]     cp2_ir,
  output logic [DATA_W-1:0]     cp2_tdata,
  input  logic                  cp2_abusy,
  input  logic                  cp2_tbusy,
  input  logic                  cp2_fbusy,
  input  logic                  cp2_tds,
  input  logic                  cp2_fds,
  input  logic [DATA_W-1:0]     cp2_fdata,
  input  logic                  cp2_excs,
  input  logic [EXC_W-1:0]      cp2_exccode
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT - 1);

  localparam logic [1:0] OpAs = 2'b01;
  localparam logic [1:0] OpTs = 2'b10;
  localparam logic [1:0] OpFs = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [1:0]          op_q, op_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                exc_q, exc_d;
  logic [EXC_W-1:0]    code_q, code_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;

  logic [1:0] elig;
  logic       owner_valid;
  logic       op_busy;
  logic       op_complete;
  logic       strobe_go;

  assign elig[0] = req_valid[0] & (req_op[1:0] != 2'b00);
  assign elig[1] = req_valid[1] & (req_op[3:2] != 2'b00);

  assign owner_valid = req_valid[owner_q];

  always_comb begin
    op_busy     = 1'b1;
    op_complete = 1'b0;
    unique case (op_q)
      OpAs: begin
        op_busy     = cp2_abusy;
        op_complete = ~cp2_abusy;
      end
      OpTs: begin
        op_busy     = cp2_tbusy;
        op_complete = cp2_tds;
      end
      OpFs: begin
        op_busy     = cp2_fbusy;
        op_complete = cp2_fds;
      end
      default: begin
        op_busy     = 1'b1;
        op_complete = 1'b0;
      end
    endcase
  end

  // Strobe only while the owner still holds its request; a drop in ISSUE aborts cleanly.
  assign strobe_go = (state_q == StIssue) & owner_valid & ~op_busy;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    timer_d = timer_q;
    exc_d   = exc_q;
    code_d  = code_q;
    fdata_d = fdata_q;

    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          if (elig == 2'b11) begin
            owner_d = ~last_q;
          end else begin
            owner_d = elig[1];
          end
          op_d    = owner_d ? req_op[3:2] : req_op[1:0];
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (!owner_valid) begin
          state_d = StIdle;
        end else if (strobe_go) begin
          timer_d = '0;
          state_d = StWait;
        end
      end

      StWait: begin
        timer_d = timer_q + 1'b1;
        if (cp2_excs) begin
          exc_d   = 1'b1;
          code_d  = cp2_exccode;
          fdata_d = '0;
          state_d = StDone;
        end else if (op_complete) begin
          exc_d   = 1'b0;
          code_d  = '0;
          fdata_d = (op_q == OpFs) ? cp2_fdata : '0;
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          exc_d   = 1'b1;
          code_d  = TIMEOUT_CODE;
          fdata_d = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 2'b00;
      timer_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      timer_q <= timer_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    grant       = 2'b00;
    req_done    = 2'b00;
    rsp_exc     = 1'b0;
    rsp_exccode = '0;
    rsp_fdata   = '0;
    cp2_ir      = '0;
    cp2_tdata   = '0;

    if (state_q != StIdle) begin
      grant = owner_q ? 2'b10 : 2'b01;
    end
    if (state_q == StIssue) begin
      cp2_ir    = owner_q ? req_ir[2*DATA_W-1:DATA_W]    : req_ir[DATA_W-1:0];
      cp2_tdata = owner_q ? req_tdata[2*DATA_W-1:DATA_W] : req_tdata[DATA_W-1:0];
    end
    if (state_q == StDone) begin
      req_done    = owner_q ? 2'b10 : 2'b01;
      rsp_exc     = exc_q;
      rsp_exccode = code_q;
      rsp_fdata   = fdata_q;
    end
  end

  assign cp2_as   = strobe_go & (op_q == OpAs);
  assign cp2_ts   = strobe_go & (op_q == OpTs);
  assign cp2_fs   = strobe_go & (op_q == OpFs);
  assign req_busy = req_valid & ~req_done;

endmodule
